// File: rtl/ram_march_sequencer_pkg.sv
// Shared types, default widths and the march data pattern for the RAM test sequencer.
package ram_test_pkg;

    localparam int DEF_ADDR_WIDTH   = 10;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_READ_LATENCY = 2;
    localparam int DEF_NUM_PASSES   = 2;
    localparam int DEF_ERR_WIDTH    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Checkerboard on address parity; odd passes use the inverted seed as base.
    function automatic logic [63:0] exp_pattern(input logic [63:0] seed,
                                                input logic        pass_odd,
                                                input logic        addr_odd);
        logic [63:0] base;
        base = pass_odd ? ~seed : seed;
        return addr_odd ? ~base : base;
    endfunction

endpackage

// File: rtl/ram_march_sequencer_if.sv
// Single-port RAM test bus: the sequencer drives address/control, the RAM returns q.
interface ram_march_sequencer_if
    import ram_test_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  wren;
    logic [DATA_WIDTH-1:0] data_to_write;
    logic                  clk_enable;
    logic [DATA_WIDTH-1:0] q;

    modport master (output address, wren, data_to_write, clk_enable, input q);
    modport slave  (input address, wren, data_to_write, clk_enable, output q);
endinterface

// File: rtl/ram_march_sequencer_read_compare_pipe.sv
// Delay line carrying {valid, addr, expected} alongside the RAM read latency, plus the q comparator.
module read_compare_pipe
    import ram_test_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_vld,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_exp,
    input  logic [DATA_WIDTH-1:0] q,
    output logic                  mismatch,
    output logic [ADDR_WIDTH-1:0] mismatch_addr,
    output logic [DATA_WIDTH-1:0] mismatch_data
);
    logic [READ_LATENCY-1:0] vld_p;
    logic [ADDR_WIDTH-1:0]   addr_p [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   exp_p  [READ_LATENCY];

    // Only the valid bits are flushed; stale addr/expected are harmless once invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= push_vld;
            for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        addr_p[0] <= push_addr;
        exp_p[0]  <= push_exp;
        for (int i = 1; i < READ_LATENCY; i++) begin
            addr_p[i] <= addr_p[i-1];
            exp_p[i]  <= exp_p[i-1];
        end
    end

    assign mismatch      = vld_p[READ_LATENCY-1] && (q != exp_p[READ_LATENCY-1]);
    assign mismatch_addr = addr_p[READ_LATENCY-1];
    assign mismatch_data = q;

endmodule

// File: rtl/ram_march_sequencer.sv
// Write/read march over the whole RAM for NUM_PASSES passes, with saturating error count and first-fail capture.
module ram_march_sequencer
    import ram_test_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    parameter int NUM_PASSES   = DEF_NUM_PASSES,
    parameter int ERR_WIDTH    = DEF_ERR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    ram_march_sequencer_if.master ram,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic [DATA_WIDTH-1:0] first_fail_data
);
    localparam logic [2:0] DRAIN_LAST = 3'(READ_LATENCY - 1);
    localparam logic [3:0] PASS_LAST  = 4'(NUM_PASSES - 1);

    function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] address_r, address_nxt;
    logic                  wren_r, wren_nxt;
    logic [DATA_WIDTH-1:0] wdata_r, wdata_nxt;
    logic [DATA_WIDTH-1:0] seed_r, seed_nxt;
    logic [3:0]            pass_idx, pass_idx_nxt;
    logic [2:0]            drain_cnt, drain_nxt;
    logic                  busy_nxt, done_nxt, pass_nxt;
    logic [ERR_WIDTH-1:0]  err_nxt;
    logic [ADDR_WIDTH-1:0] ffa_nxt;
    logic [DATA_WIDTH-1:0] ffd_nxt;

    logic                  push_vld;
    logic [DATA_WIDTH-1:0] exp_rd;
    logic                  mismatch;
    logic [ADDR_WIDTH-1:0] mismatch_addr;
    logic [DATA_WIDTH-1:0] mismatch_data;

    assign push_vld = (state == ST_READ);
    assign exp_rd   = DATA_WIDTH'(exp_pattern(64'(seed_r), pass_idx[0], address_r[0]));

    read_compare_pipe #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe (
        .clk          (clk),
        .reset        (reset),
        .push_vld     (push_vld),
        .push_addr    (address_r),
        .push_exp     (exp_rd),
        .q            (ram.q),
        .mismatch     (mismatch),
        .mismatch_addr(mismatch_addr),
        .mismatch_data(mismatch_data)
    );

    always_comb begin
        state_nxt    = state;
        address_nxt  = address_r;
        wren_nxt     = 1'b0;
        seed_nxt     = seed_r;
        pass_idx_nxt = pass_idx;
        drain_nxt    = drain_cnt;
        busy_nxt     = busy;
        done_nxt     = done;
        pass_nxt     = pass;
        err_nxt      = error_count;
        ffa_nxt      = first_fail_addr;
        ffd_nxt      = first_fail_data;

        // Retiring compares are booked even on the cycle the FSM changes state.
        if (mismatch) begin
            err_nxt = sat_inc(error_count);
            if (error_count == '0) begin
                ffa_nxt = mismatch_addr;
                ffd_nxt = mismatch_data;
            end
        end

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt    = ST_WRITE;
                    address_nxt  = '0;
                    wren_nxt     = 1'b1;
                    seed_nxt     = seed;
                    pass_idx_nxt = '0;
                    busy_nxt     = 1'b1;
                    done_nxt     = 1'b0;
                    pass_nxt     = 1'b0;
                    err_nxt      = '0;
                    ffa_nxt      = '0;
                    ffd_nxt      = '0;
                end
            end
            ST_WRITE: begin
                if (&address_r) begin
                    state_nxt   = ST_READ;
                    address_nxt = '0;
                end else begin
                    address_nxt = address_r + 1'b1;
                    wren_nxt    = 1'b1;
                end
            end
            ST_READ: begin
                if (&address_r) begin
                    state_nxt   = ST_DRAIN;
                    address_nxt = '0;
                    drain_nxt   = '0;
                end else begin
                    address_nxt = address_r + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    if (pass_idx == PASS_LAST) begin
                        state_nxt = ST_DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = (err_nxt == '0);
                    end else begin
                        state_nxt    = ST_WRITE;
                        pass_idx_nxt = pass_idx + 4'd1;
                        address_nxt  = '0;
                        wren_nxt     = 1'b1;
                    end
                end else begin
                    drain_nxt = drain_cnt + 3'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        wdata_nxt = wren_nxt
                  ? DATA_WIDTH'(exp_pattern(64'(seed_nxt), pass_idx_nxt[0], address_nxt[0]))
                  : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            address_r       <= '0;
            wren_r          <= 1'b0;
            wdata_r         <= '0;
            seed_r          <= '0;
            pass_idx        <= '0;
            drain_cnt       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            error_count     <= '0;
            first_fail_addr <= '0;
            first_fail_data <= '0;
        end else begin
            state           <= state_nxt;
            address_r       <= address_nxt;
            wren_r          <= wren_nxt;
            wdata_r         <= wdata_nxt;
            seed_r          <= seed_nxt;
            pass_idx        <= pass_idx_nxt;
            drain_cnt       <= drain_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
            pass            <= pass_nxt;
            error_count     <= err_nxt;
            first_fail_addr <= ffa_nxt;
            first_fail_data <= ffd_nxt;
        end
    end

    assign ram.address       = address_r;
    assign ram.wren          = wren_r;
    assign ram.data_to_write = wdata_r;
    assign ram.clk_enable    = busy;

endmodule

// File: tb/tb_ram_march_sequencer.sv
// Bench for ram_march_sequencer: two DUTs (16-bit and 4-bit error counters) against RAM models and a cycle-index model.
module tb_ram_march_sequencer;
    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int RL  = 2;
    localparam int NP  = 2;
    localparam int N   = 16;
    localparam int PER = 2 * N + RL;
    localparam int K   = NP * PER;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] seed_in = '0;
    int            fault_main = 0;
    logic          chk_en = 1'b0;

    always #5 clk = ~clk;

    ram_march_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
    ram_march_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    logic          busy_a, done_a, pass_a;
    logic [15:0]   err_a;
    logic [AW-1:0] ffa_a;
    logic [DW-1:0] ffd_a;
    logic          busy_b, done_b, pass_b;
    logic [3:0]    err_b;
    logic [AW-1:0] ffa_b;
    logic [DW-1:0] ffd_b;

    ram_march_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL),
                          .NUM_PASSES(NP), .ERR_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .start(start), .seed(seed_in), .ram(bus_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .error_count(err_a),
        .first_fail_addr(ffa_a), .first_fail_data(ffd_a));

    ram_march_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL),
                          .NUM_PASSES(NP), .ERR_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .seed(seed_in), .ram(bus_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .error_count(err_b),
        .first_fail_addr(ffa_b), .first_fail_data(ffd_b));

    // Fault modes: 0 clean, 1 bit 3 of address 6 stuck at 0, 2 every read inverted.
    function automatic logic [DW-1:0] ram_read(input int fault, input logic [DW-1:0] v, input int a);
        case (fault)
            1:       return (a == 6) ? (v & 8'hF7) : v;
            2:       return ~v;
            default: return v;
        endcase
    endfunction

    function automatic logic [DW-1:0] pat(input logic [DW-1:0] s, input int p, input int a);
        logic [DW-1:0] base;
        base = (p % 2 == 1) ? ~s : s;
        return (a % 2 == 1) ? (base ^ 8'hFF) : base;
    endfunction

    // RAM models: registered address then registered output, two-cycle read latency.
    logic [DW-1:0] mem_a [N];
    logic [DW-1:0] mem_b [N];
    logic [AW-1:0] ra_a, ra_b;
    logic [DW-1:0] q_a, q_b;

    always @(posedge clk) begin
        if (bus_a.clk_enable) begin
            if (bus_a.wren) mem_a[bus_a.address] <= bus_a.data_to_write;
            ra_a <= bus_a.address;
            q_a  <= ram_read(fault_main, mem_a[ra_a], int'(ra_a));
        end
        if (bus_b.clk_enable) begin
            if (bus_b.wren) mem_b[bus_b.address] <= bus_b.data_to_write;
            ra_b <= bus_b.address;
            q_b  <= ram_read(2, mem_b[ra_b], int'(ra_b));
        end
    end
    assign bus_a.q = q_a;
    assign bus_b.q = q_b;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // run_t: 0 = idle after reset, 1..K = cycles into the run, K+1 = done.
    int            run_t = 0;
    logic [DW-1:0] m_seed = '0;
    int            m_fault = 0;

    always @(posedge clk) begin
        if (reset) run_t <= 0;
        else if (start && (run_t == 0 || run_t > K)) begin
            run_t   <= 1;
            m_seed  <= seed_in;
            m_fault <= fault_main;
        end else if (run_t >= 1 && run_t <= K) run_t <= run_t + 1;
    end

    task automatic check_dut(input string tag, input int t, input int fault, input int maxerr,
                             input logic [AW-1:0] addr, input logic wren, input logic [DW-1:0] wdata,
                             input logic cen, input logic busy, input logic done, input logic pass,
                             input logic [15:0] err, input logic [AW-1:0] ffa, input logic [DW-1:0] ffd);
        int            p, r, cnt;
        logic [AW-1:0] e_addr;
        logic          e_wren, e_busy, e_done, found;
        logic [DW-1:0] e_data, e_ffd, v, rv;
        logic [AW-1:0] e_ffa;
        e_addr = '0; e_wren = 1'b0; e_data = '0; e_busy = 1'b0; e_done = 1'b0;
        if (t >= 1 && t <= K) begin
            p = (t - 1) / PER;
            r = (t - 1) % PER;
            e_busy = 1'b1;
            if (r < N) begin
                e_wren = 1'b1; e_addr = AW'(r); e_data = pat(m_seed, p, r);
            end else if (r < 2 * N) begin
                e_addr = AW'(r - N);
            end
        end else if (t > K) begin
            e_done = 1'b1;
        end
        // A read issued at cycle t0 becomes visible in error_count at t0+RL+1.
        cnt = 0; found = 1'b0; e_ffa = '0; e_ffd = '0;
        for (int pp = 0; pp < NP; pp++) begin
            for (int a = 0; a < N; a++) begin
                if (t > 0 && pp * PER + N + a + 1 + RL + 1 <= t) begin
                    v  = pat(m_seed, pp, a);
                    rv = ram_read(fault, v, a);
                    if (rv != v) begin
                        cnt++;
                        if (!found) begin found = 1'b1; e_ffa = AW'(a); e_ffd = rv; end
                    end
                end
            end
        end
        if (cnt > maxerr) cnt = maxerr;
        chk({tag, ".address"}, 32'(addr), 32'(e_addr));
        chk({tag, ".wren"}, 32'(wren), 32'(e_wren));
        chk({tag, ".data_to_write"}, 32'(wdata), 32'(e_data));
        chk({tag, ".clk_enable"}, 32'(cen), 32'(e_busy));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
        chk({tag, ".pass"}, 32'(pass), 32'(e_done && cnt == 0));
        chk({tag, ".error_count"}, 32'(err), 32'(cnt));
        chk({tag, ".first_fail_addr"}, 32'(ffa), 32'(e_ffa));
        chk({tag, ".first_fail_data"}, 32'(ffd), 32'(e_ffd));
    endtask

    logic [DW-1:0] wlog [0:K+1];

    always @(negedge clk) begin
        if (chk_en) begin
            if (run_t >= 1 && run_t <= K) wlog[run_t] = bus_a.data_to_write;
            check_dut("a", run_t, m_fault, 65535, bus_a.address, bus_a.wren, bus_a.data_to_write,
                      bus_a.clk_enable, busy_a, done_a, pass_a, err_a, ffa_a, ffd_a);
            check_dut("b", run_t, 2, 15, bus_b.address, bus_b.wren, bus_b.data_to_write,
                      bus_b.clk_enable, busy_b, done_b, pass_b, 16'(err_b), ffa_b, ffd_b);
        end
    end

    // lat = edges from start sampling to done, -1 on timeout, -2 when reset was injected.
    task automatic run(input logic [DW-1:0] s, input int glitch_t, input int rst_t, output int lat);
        @(negedge clk);
        start = 1'b1; seed_in = s;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 1) begin
                chk("start_done_clear", 32'(done_a), 32'h0);
                chk("start_err_clear", 32'(err_a), 32'h0);
            end
            if (n == glitch_t) begin start = 1'b1; seed_in = 8'h00; end
            else if (n == glitch_t + 1) begin start = 1'b0; seed_in = s; end
            if (n == rst_t) begin
                chk("pre_reset_addr", 32'(bus_a.address), 32'h9);
                chk("pre_reset_wren", 32'(bus_a.wren), 32'h0);
                reset = 1'b1;
            end
            if (n == rst_t + 1) begin
                reset = 1'b0;
                chk("rst_busy", 32'(busy_a), 32'h0);
                chk("rst_wren", 32'(bus_a.wren), 32'h0);
                chk("rst_address", 32'(bus_a.address), 32'h0);
                chk("rst_error_count", 32'(err_a), 32'h0);
                lat = -2;
                break;
            end
            if (done_a) begin lat = n - 1; break; end
        end
    endtask

    int lat;

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("init_busy", 32'(busy_a), 32'h0);
        chk("init_done", 32'(done_a), 32'h0);
        chk("init_wren", 32'(bus_a.wren), 32'h0);
        chk("init_address", 32'(bus_a.address), 32'h0);
        chk("init_error_count", 32'(err_a), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Clean run, plus saturation on the always-inverting second RAM.
        fault_main = 0;
        run(8'hA5, -10, -10, lat);
        chk("clean_latency", 32'(lat), 32'd68);
        chk("clean_pass", 32'(pass_a), 32'h1);
        chk("clean_errors", 32'(err_a), 32'h0);
        chk("clean_w0", 32'(wlog[1]), 32'hA5);
        chk("clean_w1", 32'(wlog[2]), 32'h5A);
        chk("clean_p1_w0", 32'(wlog[35]), 32'h5A);
        chk("clean_p1_w1", 32'(wlog[36]), 32'hA5);
        chk("sat_errors", 32'(err_b), 32'hF);
        chk("sat_ffa", 32'(ffa_b), 32'h0);
        chk("sat_ffd", 32'(ffd_b), 32'h5A);
        chk("sat_pass", 32'(pass_b), 32'h0);

        // Start pulse mid-run with a different seed must be ignored.
        run(8'hC3, 10, -10, lat);
        chk("ignore_latency", 32'(lat), 32'd68);
        chk("ignore_w0", 32'(wlog[1]), 32'hC3);
        chk("ignore_w11", 32'(wlog[12]), 32'h3C);
        chk("ignore_pass", 32'(pass_a), 32'h1);

        // Stuck-at fault on address 6 bit 3.
        fault_main = 1;
        run(8'hFF, -10, -10, lat);
        chk("stuck_latency", 32'(lat), 32'd68);
        chk("stuck_errors", 32'(err_a), 32'h1);
        chk("stuck_ffa", 32'(ffa_a), 32'h6);
        chk("stuck_ffd", 32'(ffd_a), 32'hF7);
        chk("stuck_pass", 32'(pass_a), 32'h0);

        // Restart from DONE with a clean RAM.
        fault_main = 0;
        run(8'h3C, -10, -10, lat);
        chk("restart_latency", 32'(lat), 32'd68);
        chk("restart_pass", 32'(pass_a), 32'h1);
        chk("restart_errors", 32'(err_a), 32'h0);
        chk("restart_ffa", 32'(ffa_a), 32'h0);
        chk("restart_ffd", 32'(ffd_a), 32'h0);

        // Reset during READ at address 9, then a full run.
        run(8'h96, -10, 26, lat);
        chk("reset_abort", 32'(lat), 32'hFFFF_FFFE);
        run(8'h96, -10, -10, lat);
        chk("post_reset_latency", 32'(lat), 32'd68);
        chk("post_reset_pass", 32'(pass_a), 32'h1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_march_sequencer.md
Name: ram_march_sequencer

Overview:
Self-contained test sequencer for the single-port test RAM. Fills the whole address space with an address-parity checkerboard derived from a seed, then reads it back and compares it against the expected data. It repeats this for a configurable number of passes, inverting the pattern on odd passes. It replaces the fixed-address, read-only stimulus with a full write/read march and reports pass/fail, a saturating error count and the first failing location.

Parameters:
ADDR_WIDTH, 10, RAM address width; N = 2**ADDR_WIDTH words
DATA_WIDTH, 8, RAM word width
READ_LATENCY, 2, clocks from address presented to q valid (registered address plus registered output); legal range 1..4
NUM_PASSES, 2, number of write/read passes per run; legal range 1..15
ERR_WIDTH, 16, width of the saturating error counter

Ports:
clk  in  1  single clock for the sequencer and the RAM port
reset  in  1  synchronous, active-high reset
start  in  1  run request; sampled only in IDLE or DONE
seed  in  DATA_WIDTH  base pattern; latched when start is accepted
address  out  ADDR_WIDTH  RAM address
wren  out  1  RAM write enable
data_to_write  out  DATA_WIDTH  RAM write data
clk_enable  out  1  RAM clock enable; high whenever busy
q  in  DATA_WIDTH  RAM read data
busy  out  1  run in progress
done  out  1  run complete; held until the next accepted start
pass  out  1  high with done when error_count == 0
error_count  out  ERR_WIDTH  mismatching reads, saturating
first_fail_addr  out  ADDR_WIDTH  address of the first mismatch
first_fail_data  out  DATA_WIDTH  q value at the first mismatch

Behaviour:
- Reset (any state, including mid-run) forces IDLE. All outputs go to 0, the read pipeline is flushed and the latched seed is cleared.
- States: IDLE, WRITE, READ, DRAIN, DONE. All outputs are registered.
- Start acceptance: start=1 in IDLE or DONE latches seed, clears pass_idx, error_count, first_fail_* and done, then moves to WRITE with address=0. start is ignored in WRITE, READ and DRAIN.
- Expected data: base = pass_idx[0] ? ~seed : seed; exp(a) = a[0] ? ~base : base.
- WRITE: wren=1, data_to_write=exp(address), address increments by 1 each cycle. In the cycle address == N-1, the next state is READ and address resets to 0. There is no wrap-around write.
- READ: wren=0, data_to_write=0. Each cycle, {valid=1, addr, exp(addr)} is pushed into a READ_LATENCY-deep delay line, and address increments. After address N-1 is issued, the next state is DRAIN.
- DRAIN: lasts exactly READ_LATENCY cycles with no new reads. Then, if pass_idx == NUM_PASSES-1 go to DONE; otherwise increment pass_idx and go to WRITE at address 0.
- Compare: when the delay-line output is valid and q != expected:
  - error_count += 1, saturating at all-ones;
  - if this is the first error of the run, capture first_fail_addr and first_fail_data=q.
  - Comparisons that retire in the same cycle the state changes are still counted.
- DONE: busy=0, done=1, pass=(error_count==0), wren=0, clk_enable=0.
- Timing: done rises NUM_PASSES*(2N+READ_LATENCY) cycles after the cycle in which start was sampled. busy is high for exactly that many cycles.
- Restart from DONE clears done and pass in the cycle following acceptance.

Decomposition:
- Package ram_test_pkg holds:
  - the state enum (IDLE/WRITE/READ/DRAIN/DONE);
  - the function exp_pattern(seed, pass_idx, addr);
  - the default widths.
- One sub-module, read_compare_pipe: parameterised delay line of {valid, addr, expected}, plus a comparator that outputs mismatch, mismatch_addr and mismatch_data.
- The FSM, counters and error bookkeeping stay in ram_march_sequencer.

Test Plan:
All scenarios use ADDR_WIDTH=4, READ_LATENCY=2, NUM_PASSES=2 and a behavioural RAM model with 2-cycle read latency.
1. Clean run: seed=8'hA5 -> done=1 exactly 68 cycles after start; pass=1, error_count=0. Writes in pass 0 are A5/5A alternating; writes in pass 1 are 5A/A5.
2. Stuck-at fault: model forces bit 3 of address 4'h6 to 0, seed=8'hFF -> addr 6 expects FF in pass 0 and 00 in pass 1. Required result: error_count=1, first_fail_addr=4'h6, first_fail_data=8'hF7, pass=0.
3. Saturation: build with ERR_WIDTH=4 and a model whose q is always ~expected -> error_count stops at 4'hF; first_fail_addr=0.
4. Start ignored while busy: pulse start at cycle 10 with seed=8'h00 -> run continues with the original seed; done still rises at cycle 68.
5. Reset mid-run: assert reset during READ at address 4'h9 -> next cycle busy=0, wren=0, address=0, error_count=0. A subsequent start completes normally in 68 cycles.
6. Restart from DONE: after run 1 (with a fault), start with seed=8'h3C and a fault-free model -> error_count and first_fail_* are cleared, and the run ends with pass=1.
